// File: rtl/al_accel_pkg.sv
// al_accel_pkg: shared accelerator constants and the oreg FSM state encoding
package al_accel_pkg;
  localparam int ACCEL_DW = 8;
  localparam int ACCEL_PACK = 4;
  typedef enum logic [1:0] {RUN, PAD, DRAIN} oreg_state_t;
endpackage

// File: rtl/al_accel_sfifo.sv
// al_accel_sfifo: sync FIFO (clk, resetn, push/din in, pop/dout out, full/empty/lvl status); dout reads 0 when empty
module al_accel_sfifo #(
  parameter int W = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     lvl
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = lvl == '0;
  assign full = lvl == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
      lvl <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      lvl <= lvl + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/al_accel_oreg.sv
// al_accel_oreg: packs core results (oreg_di/vld/rdy) into words, FIFOs them to the bus (oreg_do/last/vld/rdy, oreg_lvl), flush/flush_done closes a run
module al_accel_oreg
  import al_accel_pkg::*;
#(
  parameter int DW = ACCEL_DW,
  parameter int PACK = ACCEL_PACK,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      enb,
  input  logic [DW-1:0]             oreg_di,
  input  logic                      oreg_vld,
  output logic                      oreg_rdy,
  input  logic                      flush,
  output logic [DW*PACK-1:0]        oreg_do,
  output logic                      oreg_do_last,
  output logic                      oreg_do_vld,
  input  logic                      oreg_do_rdy,
  output logic [$clog2(DEPTH):0]    oreg_lvl,
  output logic                      flush_done
);
  localparam int OW = DW*PACK;
  localparam int IW = $clog2(PACK);
  oreg_state_t state;
  logic [IW-1:0] byte_idx, idx_nxt;
  logic [OW-1:0] pack_q, pack_ins;
  logic flush_q, full, empty, acc, last_lane, push;
  logic [OW:0] fifo_dout;
  assign last_lane = byte_idx == IW'(PACK-1);
  assign oreg_rdy = resetn & enb & (state == RUN) & ~(last_lane & full);
  assign acc = oreg_vld & oreg_rdy;
  assign idx_nxt = acc ? (last_lane ? '0 : byte_idx + 1'b1) : byte_idx;
  assign push = (acc & last_lane) | (state == PAD & ~full);
  assign oreg_do = fifo_dout[OW-1:0];
  assign oreg_do_last = fifo_dout[OW];
  assign oreg_do_vld = ~empty;
  always_comb begin
    pack_ins = pack_q;
    if (acc) pack_ins[DW*byte_idx +: DW] = oreg_di;
  end
  al_accel_sfifo #(.W(OW+1), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push(push),
    .din({state == PAD, pack_ins}),
    .pop(oreg_do_rdy),
    .dout(fifo_dout),
    .full(full),
    .empty(empty),
    .lvl(oreg_lvl)
  );
  // pack_q is cleared whenever a word leaves it, so unused lanes of a padded word are already zero
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= RUN;
      byte_idx <= '0;
      pack_q <= '0;
      flush_q <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_q <= flush & (state == RUN);
      flush_done <= 1'b0;
      byte_idx <= idx_nxt;
      pack_q <= (acc & last_lane) ? '0 : pack_ins;
      case (state)
        RUN: if (flush_q) state <= (idx_nxt != '0) ? PAD : DRAIN;
        PAD: if (!full) begin
          state <= DRAIN;
          byte_idx <= '0;
          pack_q <= '0;
        end
        DRAIN: if (oreg_lvl == '0) begin
          flush_done <= 1'b1;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_al_accel_oreg.sv
// tb_al_accel_oreg: directed vector table plus hand sequences for al_accel_oreg
module tb_al_accel_oreg;
  logic clk = 1'b0;
  logic resetn, enb, oreg_vld, flush, oreg_do_rdy;
  logic [7:0] oreg_di;
  logic oreg_rdy, oreg_do_last, oreg_do_vld, flush_done;
  logic [31:0] oreg_do;
  logic [2:0] oreg_lvl;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic vld;
    logic [7:0] di;
    logic en;
    logic e_rdy;
    logic e_dvld;
    logic [31:0] e_do;
    logic e_last;
    logic [2:0] e_lvl;
    logic e_fd;
  } vec_t;
  vec_t tv[$];

  al_accel_oreg dut (
    .clk(clk),
    .resetn(resetn),
    .enb(enb),
    .oreg_di(oreg_di),
    .oreg_vld(oreg_vld),
    .oreg_rdy(oreg_rdy),
    .flush(flush),
    .oreg_do(oreg_do),
    .oreg_do_last(oreg_do_last),
    .oreg_do_vld(oreg_do_vld),
    .oreg_do_rdy(oreg_do_rdy),
    .oreg_lvl(oreg_lvl),
    .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic e, input logic r,
                     input logic dv, input logic [31:0] dd, input logic l, input logic [2:0] lv, input logic fd);
    tv.push_back('{v, d, e, r, dv, dd, l, lv, fd});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int n;
    logic seen;
    // t1: one word, then t5: enb gap mid-word
    add(1, 8'h11, 1, 1, 0, 32'h0, 0, 0, 0);
    add(1, 8'h22, 1, 1, 0, 32'h0, 0, 0, 0);
    add(1, 8'h33, 1, 1, 0, 32'h0, 0, 0, 0);
    add(1, 8'h44, 1, 1, 1, 32'h44332211, 0, 1, 0);
    add(0, 8'h00, 1, 1, 0, 32'h0, 0, 0, 0);
    add(1, 8'h01, 1, 1, 0, 32'h0, 0, 0, 0);
    add(1, 8'h02, 1, 1, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 8'hFF, 0, 0, 0, 32'h0, 0, 0, 0);
    add(1, 8'h03, 1, 1, 0, 32'h0, 0, 0, 0);
    add(1, 8'h04, 1, 1, 1, 32'h04030201, 0, 1, 0);
    add(0, 8'h00, 1, 1, 0, 32'h0, 0, 0, 0);

    resetn = 0; enb = 1; oreg_vld = 1; oreg_di = 8'h55; flush = 0; oreg_do_rdy = 1;
    @(negedge clk);
    #1 chk("rst_rdy", oreg_rdy, 0);
    tick;
    oreg_vld = 0;
    tick;
    resetn = 1;
    chk("rst_vld", oreg_do_vld, 0);
    chk("rst_do", oreg_do, 0);
    chk("rst_last", oreg_do_last, 0);
    chk("rst_lvl", oreg_lvl, 0);
    chk("rst_fd", flush_done, 0);

    foreach (tv[k]) begin
      oreg_vld = tv[k].vld; oreg_di = tv[k].di; enb = tv[k].en;
      #1 chk($sformatf("v%0d_rdy", k), oreg_rdy, tv[k].e_rdy);
      tick;
      chk($sformatf("v%0d_dvld", k), oreg_do_vld, tv[k].e_dvld);
      chk($sformatf("v%0d_do", k), oreg_do, tv[k].e_do);
      chk($sformatf("v%0d_last", k), oreg_do_last, tv[k].e_last);
      chk($sformatf("v%0d_lvl", k), oreg_lvl, tv[k].e_lvl);
      chk($sformatf("v%0d_fd", k), flush_done, tv[k].e_fd);
    end
    oreg_vld = 0; enb = 1;

    // t2: backpressure until full, stall only on lane 3 of word 5
    oreg_do_rdy = 0;
    for (int i = 0; i < 19; i++) begin
      oreg_vld = 1; oreg_di = 8'(i);
      #1 chk("t2_rdy", oreg_rdy, 1);
      tick;
    end
    chk("t2_lvl_full", oreg_lvl, 4);
    oreg_di = 8'h13;
    #1 chk("t2_stall", oreg_rdy, 0);
    tick;
    #1 chk("t2_stall2", oreg_rdy, 0);
    chk("t2_lvl_hold", oreg_lvl, 4);
    oreg_do_rdy = 1;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      #1;
      if (oreg_do_vld) begin
        chk("t2_word", oreg_do, 32'h03020100 + 32'h04040404 * n);
        n++;
      end
      acc = oreg_vld & oreg_rdy;
      tick;
      if (acc) oreg_vld = 0;
    end
    chk("t2_count", n, 5);
    chk("t2_lvl_end", oreg_lvl, 0);
    oreg_vld = 0;

    // t3: partial word flush gets padded and tagged
    oreg_vld = 1; oreg_di = 8'hA1; tick;
    oreg_di = 8'hB2; tick;
    oreg_vld = 0; flush = 1; tick;
    flush = 0; tick;
    chk("t3_pad_rdy", oreg_rdy, 0);
    chk("t3_pad_vld", oreg_do_vld, 0);
    tick;
    chk("t3_vld", oreg_do_vld, 1);
    chk("t3_do", oreg_do, 32'h0000B2A1);
    chk("t3_last", oreg_do_last, 1);
    chk("t3_drain_rdy", oreg_rdy, 0);
    chk("t3_fd0", flush_done, 0);
    tick;
    chk("t3_drain_rdy2", oreg_rdy, 0);
    chk("t3_vld2", oreg_do_vld, 0);
    chk("t3_fd1", flush_done, 0);
    tick;
    chk("t3_fd", flush_done, 1);
    chk("t3_run_rdy", oreg_rdy, 1);
    tick;
    chk("t3_fd_pulse", flush_done, 0);

    // t4: flush on a word boundary with 2 words queued, bus toggling
    oreg_do_rdy = 0;
    for (int i = 0; i < 8; i++) begin
      oreg_vld = 1; oreg_di = 8'(8'h50 + i); tick;
    end
    oreg_vld = 0;
    chk("t4_lvl", oreg_lvl, 2);
    flush = 1; tick;
    flush = 0;
    n = 0; seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      oreg_do_rdy = c[0];
      #1;
      chk("t4_nopad", oreg_do_vld & oreg_do_last, 0);
      if (flush_done) begin
        chk("t4_lvl0", oreg_lvl, 0);
        chk("t4_pops", n, 2);
        seen = 1;
      end
      if (oreg_do_vld & oreg_do_rdy) begin
        chk("t4_word", oreg_do, n == 0 ? 32'h53525150 : 32'h57565554);
        n++;
      end
      tick;
    end
    chk("t4_done", seen, 1);

    // t7: flush latency with nothing buffered
    oreg_do_rdy = 1;
    flush = 1; tick;
    flush = 0;
    chk("t7_fd_n", flush_done, 0);
    tick;
    chk("t7_fd_n1", flush_done, 0);
    tick;
    chk("t7_fd_n2", flush_done, 1);
    tick;
    chk("t7_fd_n3", flush_done, 0);

    // t6: reset mid-word with words queued discards everything
    oreg_do_rdy = 0;
    for (int i = 0; i < 11; i++) begin
      oreg_vld = 1; oreg_di = 8'(8'h60 + i); tick;
    end
    oreg_vld = 0;
    chk("t6_lvl", oreg_lvl, 2);
    resetn = 0; tick;
    resetn = 1;
    chk("t6_lvl0", oreg_lvl, 0);
    chk("t6_vld0", oreg_do_vld, 0);
    chk("t6_do0", oreg_do, 0);
    oreg_do_rdy = 1;
    oreg_vld = 1;
    oreg_di = 8'hDE; tick;
    oreg_di = 8'hAD; tick;
    oreg_di = 8'hBE; tick;
    oreg_di = 8'hEF; tick;
    oreg_vld = 0;
    chk("t6_vld", oreg_do_vld, 1);
    chk("t6_do", oreg_do, 32'hEFBEADDE);
    chk("t6_last", oreg_do_last, 0);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
